rgb_memory_top: RTL and testbench
=================================

RGB_MEMORY_TOP -- requirements
Module: rgb_memory_top

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and reset_n as the codebase names them; reset_n is active-high despite its name.
REQ-002 Parameters SHALL be: RAMLENGTH 800 (words per channel RAM); DATA_WIDTH 6 (bits per word); ADDR_WIDTH 10 (word address width); X_WIRE_WIDTH 11 (hpos width); Y_WIRE_WIDTH 10 (vpos width); RESOLUTION_H 640 (screen width); RESOLUTION_V 480 (screen height).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset_n  input  1  synchronous active-high reset.
REQ-005 display_on  input  1  1 = display/read mode, 0 = write mode.
REQ-006 memreset  input  1  active-low memory clear enable.
REQ-007 resetcnt  input  ADDR_WIDTH  word address cleared while memreset=0.
REQ-008 RGBin  input  3  pixel write data {R,G,B}.
REQ-009 hpos  input  X_WIRE_WIDTH  x coordinate (screen in read mode, framebuffer in write mode).
REQ-010 vpos  input  Y_WIRE_WIDTH  y coordinate (same convention as hpos).
REQ-011 fifoempty  input  1  1 = no valid write data available.
REQ-012 RGB  output  3  registered pixel colour {R,G,B}.

Function
REQ-013 Storage SHALL be an 80x60 framebuffer of 3-bit pixels: three channel RAMs (R, G, B), each RAMLENGTH x DATA_WIDTH bits, one bit per pixel per channel.
REQ-014 Pixel (x,y) SHALL map to word address (y/6)*80 + x and bit select y%6; e.g. (60,50) -> word 700, bit 2; (40,20) -> 280, bit 2; (70,10) -> 150, bit 4; (79,59) -> 799, bit 5.
REQ-015 Write mode (display_on=0, memreset=1, fifoempty=0, x<80, y<60, with x=hpos, y=vpos) SHALL store RGBin[2], RGBin[1], RGBin[0] into the selected bit of the R, G, B RAMs respectively.
REQ-016 A write SHALL modify only the selected bit; the other 5 bits of the word are preserved, via a bit-enable write or a read-modify-write.
REQ-017 A write SHALL complete within 3 clocks while hpos, vpos and RGBin are held stable; repeating the write of identical data while the inputs are held SHALL be harmless.
REQ-018 Writes SHALL be suppressed when fifoempty=1 or when the coordinates are out of range (hpos>=80 or vpos>=60).
REQ-019 Read mode (display_on=1) SHALL scale the coordinates to x=hpos/8 and y=vpos/8, the 640/80 and 480/60 ratios; an implementation SHALL truncate by shifting right by 3.
REQ-020 RGB SHALL equal the stored pixel at the scaled address one clock after hpos/vpos are presented, giving a read latency of 1 cycle.
REQ-021 In read mode, if hpos>=RESOLUTION_H or vpos>=RESOLUTION_V, RGB SHALL be 3'b000 on the next clock.
REQ-022 RGB SHALL be 3'b000 on the clock after display_on=0.
REQ-023 Clear: while memreset=0, each clock SHALL write all-zero to word resetcnt in all three RAMs; writes are suppressed while clearing.
REQ-024 Clear SHALL ignore a resetcnt >= RAMLENGTH.
REQ-025 Priority SHALL be reset > clear (memreset=0) > pixel write > read.
REQ-026 Memory contents SHALL NOT be initialised by reset; only the clear path zeroes them.

Reset
REQ-027 On reset_n=1 at a rising edge, RGB SHALL become 3'b000 and any in-progress write or read-modify-write SHALL be aborted without corrupting memory beyond the addressed word.
REQ-028 After reset deasserts, the block SHALL accept clear, write or read on the next clock.

Verification
REQ-029 Reset, then resetcnt swept 0..799 with memreset=0, then memreset=1, display_on=1, hpos/vpos swept over the screen -> RGB=000 everywhere.
REQ-030 Write mode: (60,50)=011, (40,20)=101 and (70,10)=110, each held 5 clocks; then read mode at (480,400), (320,160) and (560,80) -> RGB 011, 101, 110 respectively, each one clock after presentation.
REQ-031 Bit isolation: write (60,48)=111, then (60,50)=010, then read (480,384) -> 111 and read (480,400) -> 010.
REQ-032 Ten random writes (x in 0..79, y in 0..59, data in 0..7), then reads at (8x,8y) -> each RGB equals the written data.
REQ-033 Write (10,10)=111 with fifoempty=1, then read (80,80) -> 000; read (700,10) -> 000.
REQ-034 Assert reset_n mid-write -> RGB=000 on the next clock, and the write of unrelated words is not affected.

Source files
------------

// File: rtl/rgb_memory_top.sv
// 80x60 3-bit framebuffer stored as three 800x6 channel RAMs (one bit per pixel per word).
// Write mode stores a pixel via bit-enable write; read mode scales screen coords by 8.
module rgb_memory_top #(
    parameter int RAMLENGTH    = 800,
    parameter int DATA_WIDTH   = 6,
    parameter int ADDR_WIDTH   = 10,
    parameter int X_WIRE_WIDTH = 11,
    parameter int Y_WIRE_WIDTH = 10,
    parameter int RESOLUTION_H = 640,
    parameter int RESOLUTION_V = 480
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    display_on,
    input  logic                    memreset,
    input  logic [ADDR_WIDTH-1:0]   resetcnt,
    input  logic [2:0]              RGBin,
    input  logic [X_WIRE_WIDTH-1:0] hpos,
    input  logic [Y_WIRE_WIDTH-1:0] vpos,
    input  logic                    fifoempty,
    output logic [2:0]              RGB
);
    localparam int FB_W = 80;
    localparam int FB_H = 60;

    logic [DATA_WIDTH-1:0] mem_r [RAMLENGTH];
    logic [DATA_WIDTH-1:0] mem_g [RAMLENGTH];
    logic [DATA_WIDTH-1:0] mem_b [RAMLENGTH];

    logic [X_WIRE_WIDTH-1:0] sx;
    logic [Y_WIRE_WIDTH-1:0] sy;
    logic [6:0]              px;
    logic [5:0]              py;
    logic [5:0]              row;
    logic [2:0]              bsel;
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    clear_en;
    logic                    wr_en;
    logic                    rd_ok;

    // Read mode looks at screen coordinates, write mode at framebuffer coordinates.
    always_comb begin
        sx   = display_on ? (hpos >> 3) : hpos;
        sy   = display_on ? (vpos >> 3) : vpos;
        px   = sx[6:0];
        py   = sy[5:0];
        row  = py / 6'd6;
        bsel = 3'(py % 6'd6);
        addr = ADDR_WIDTH'(row) * ADDR_WIDTH'(FB_W) + ADDR_WIDTH'(px);
    end

    assign clear_en = !reset_n && !memreset && (32'(resetcnt) < RAMLENGTH);
    assign wr_en    = !reset_n && memreset && !display_on && !fifoempty &&
                      (32'(hpos) < FB_W) && (32'(vpos) < FB_H);
    assign rd_ok    = (32'(hpos) < RESOLUTION_H) && (32'(vpos) < RESOLUTION_V);

    // No reset on the arrays: contents survive reset, only the clear path zeroes them.
    always_ff @(posedge clk) begin
        if (clear_en) begin
            mem_r[resetcnt] <= '0;
            mem_g[resetcnt] <= '0;
            mem_b[resetcnt] <= '0;
        end else if (wr_en) begin
            mem_r[addr][bsel] <= RGBin[2];
            mem_g[addr][bsel] <= RGBin[1];
            mem_b[addr][bsel] <= RGBin[0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n)
            RGB <= 3'b000;
        else if (!display_on || !rd_ok)
            RGB <= 3'b000;
        else
            RGB <= {mem_r[addr][bsel], mem_g[addr][bsel], mem_b[addr][bsel]};
    end
endmodule

// File: tb/tb_rgb_memory_top.sv
// Randomized self-checking bench for rgb_memory_top against a pixel-array reference model.
module tb_rgb_memory_top;
    logic        clk = 0;
    logic        reset_n;
    logic        display_on;
    logic        memreset;
    logic [9:0]  resetcnt;
    logic [2:0]  RGBin;
    logic [10:0] hpos;
    logic [9:0]  vpos;
    logic        fifoempty;
    logic [2:0]  RGB;

    int checks = 0;
    int failures = 0;

    logic [2:0] model [80][60];
    bit         known [80][60];

    rgb_memory_top dut (
        .clk(clk), .reset_n(reset_n), .display_on(display_on), .memreset(memreset),
        .resetcnt(resetcnt), .RGBin(RGBin), .hpos(hpos), .vpos(vpos),
        .fifoempty(fifoempty), .RGB(RGB)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int x, input int y, input logic [2:0] d);
        display_on = 0; fifoempty = 0; hpos = 11'(x); vpos = 10'(y); RGBin = d;
        repeat (5) tick();
        fifoempty = 1;
        if (x < 80 && y < 60) begin
            model[x][y] = d;
            known[x][y] = 1;
        end
    endtask

    // Present a screen coordinate and check RGB one clock later.
    task automatic do_read(input int h, input int v, input string name);
        logic [2:0] exp;
        bit         chk;
        display_on = 1; hpos = 11'(h); vpos = 10'(v);
        tick();
        chk = 1; exp = 3'b000;
        if (h < 640 && v < 480) begin
            chk = known[h/8][v/8];
            exp = model[h/8][v/8];
        end
        if (chk) begin
            checks++;
            if (RGB !== exp) begin
                failures++;
                $display("FAIL %s (h=%0d v=%0d): got %b expected %b", name, h, v, RGB, exp);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1; display_on = 1; hpos = 0; vpos = 0;
        tick(); tick();
        checks++;
        if (RGB !== 3'b000) begin
            failures++;
            $display("FAIL reset_rgb: got %b expected 000", RGB);
        end
        reset_n = 0;
    endtask

    task automatic test_clear();
        memreset = 0;
        for (int i = 0; i < 800; i++) begin
            resetcnt = 10'(i);
            tick();
        end
        resetcnt = 10'd1000;
        tick();
        memreset = 1;
        for (int x = 0; x < 80; x++)
            for (int y = 0; y < 60; y++) begin
                model[x][y] = 3'b000;
                known[x][y] = 1;
            end
        for (int v = 0; v < 480; v += 8)
            for (int h = 0; h < 640; h += 8)
                do_read(h, v, "clear_sweep");
    endtask

    task automatic test_write_read();
        do_write(60, 50, 3'b011);
        do_write(40, 20, 3'b101);
        do_write(70, 10, 3'b110);
        do_read(480, 400, "wr_60_50");
        do_read(320, 160, "wr_40_20");
        do_read(560, 80, "wr_70_10");
        display_on = 0;
        tick();
        checks++;
        if (RGB !== 3'b000) begin
            failures++;
            $display("FAIL display_off: got %b expected 000", RGB);
        end
    endtask

    task automatic test_bit_isolation();
        do_write(60, 48, 3'b111);
        do_write(60, 50, 3'b010);
        do_read(480, 384, "iso_60_48");
        do_read(480, 400, "iso_60_50");
        // neighbours sharing the word
        for (int y = 48; y < 54; y++) do_read(480, y * 8, "iso_word");
    endtask

    task automatic test_random();
        int xs[10], ys[10];
        for (int i = 0; i < 10; i++) begin
            xs[i] = $urandom_range(79);
            ys[i] = $urandom_range(59);
            do_write(xs[i], ys[i], 3'($urandom_range(7)));
        end
        for (int i = 0; i < 10; i++) do_read(xs[i] * 8, ys[i] * 8, "random");
    endtask

    task automatic test_suppressed();
        display_on = 0; fifoempty = 1; hpos = 10; vpos = 10; RGBin = 3'b111;
        repeat (5) tick();
        do_read(80, 80, "fifoempty_blk");
        do_read(700, 10, "h_out_of_range");
        do_read(10, 500, "v_out_of_range");
        // out-of-range framebuffer coords must not alias into memory
        display_on = 0; fifoempty = 0; hpos = 80 + 5; vpos = 3; RGBin = 3'b111;
        repeat (3) tick();
        hpos = 5; vpos = 60;
        repeat (3) tick();
        fifoempty = 1;
        for (int x = 0; x < 80; x++) do_read(x * 8, 0, "oob_row0");
        for (int y = 0; y < 60; y++) do_read(40, y * 8, "oob_col5");
    endtask

    task automatic test_reset_midwrite();
        do_write(30, 30, 3'b101);
        display_on = 1; hpos = 240; vpos = 240;
        tick();
        reset_n = 1;
        tick();
        checks++;
        if (RGB !== 3'b000) begin
            failures++;
            $display("FAIL reset_mid_read: got %b expected 000", RGB);
        end
        reset_n = 0;
        // start a write and reset it on its first edge
        display_on = 0; fifoempty = 0; hpos = 20; vpos = 31; RGBin = 3'b111;
        reset_n = 1;
        tick();
        reset_n = 0; fifoempty = 1;
        known[20][31] = 0;
        tick();
        for (int x = 0; x < 80; x++)
            for (int y = 24; y < 36; y++)
                do_read(x * 8, y * 8, "post_reset");
    endtask

    initial begin
        reset_n = 1; display_on = 0; memreset = 1; resetcnt = 0; RGBin = 0;
        hpos = 0; vpos = 0; fifoempty = 1;
        for (int x = 0; x < 80; x++)
            for (int y = 0; y < 60; y++) known[x][y] = 0;
        test_reset();
        test_clear();
        test_write_read();
        test_bit_isolation();
        test_random();
        test_suppressed();
        test_reset_midwrite();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
